conv_decoder_bs: RTL

//  Hard-decision, error-free inverse of the rate-1/3 K=7 convolutional encoder (generators 133/171/165 octal).

---
 rtl/conv_code_pkg.sv | 39 +++
 rtl/conv_decoder_bs_if.sv | 30 +++
 rtl/conv_bit_inverter.sv | 23 ++
 rtl/conv_decoder_bs.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/conv_code_pkg.sv
// Shared constants, FSM state type and tap helper for the K=7 rate-1/3 convolutional code.
package conv_code_pkg;

  localparam int unsigned K               = 7;
  localparam int unsigned SR_W            = K - 1;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned ERR_W           = 16;
  localparam int unsigned ERR_SUM_W       = ERR_W + 1;
  localparam int unsigned LEN_SMALL_BYTES = 132;
  localparam int unsigned LEN_LARGE_BYTES = 768;
  localparam int unsigned CNT_W           = $clog2(LEN_LARGE_BYTES);

  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o165;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_WRITE,
    ST_DONE
  } dec_state_e;

  // Parity of generator taps over {current bit, s0..s5}; g[K-1] taps the current bit.
  function automatic logic tap_parity(input logic [K-1:0] g,
                                      input logic cur,
                                      input logic [SR_W-1:0] s);
    logic [K-1:0] r;
    r[K-1] = cur;
    for (int i = 0; i < int'(SR_W); i++) begin
      r[SR_W-1-i] = s[i];
    end
    return ^(g & r);
  endfunction

endpackage

// File: rtl/conv_decoder_bs_if.sv
// Subblock-FIFO read side, output-FIFO write side and control/status of the decoder.
interface conv_decoder_bs_if;
  import conv_code_pkg::*;

  logic              start;
  logic              code_block_length;
  logic [SR_W-1:0]   init_state;
  logic              empty;
  logic [BYTE_W-1:0] q0;
  logic [BYTE_W-1:0] q1;
  logic [BYTE_W-1:0] q2;
  logic              rdreq_subblock;
  logic              out_full;
  logic              out_wrreq;
  logic [BYTE_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_count;

  modport slave (
    input  start, code_block_length, init_state, empty, q0, q1, q2, out_full,
    output rdreq_subblock, out_wrreq, out_data, busy, done, err_count
  );

  modport master (
    output start, code_block_length, init_state, empty, q0, q1, q2, out_full,
    input  rdreq_subblock, out_wrreq, out_data, busy, done, err_count
  );

endinterface

// File: rtl/conv_bit_inverter.sv
// One-bit inverse of the encoder: recovers the info bit from the g0 stream and
// counts how many of the re-encoded g1/g2 bits disagree with the received ones.
module conv_bit_inverter
  import conv_code_pkg::*;
(
  input  logic            d0_i,
  input  logic            d1_i,
  input  logic            d2_i,
  input  logic [SR_W-1:0] s_i,
  output logic            bit_c,
  output logic [1:0]      mis_cnt_c
);

  logic e1;
  logic e2;

  // g0 taps the current bit, so XOR-ing out the state taps yields it exactly.
  assign bit_c     = d0_i ^ tap_parity(G0, 1'b0, s_i);
  assign e1        = tap_parity(G1, bit_c, s_i);
  assign e2        = tap_parity(G2, bit_c, s_i);
  assign mis_cnt_c = 2'(e1 != d1_i) + 2'(e2 != d2_i);

endmodule

// File: rtl/conv_decoder_bs.sv
// Byte-stream decoder for the rate-1/3 K=7 encoder: pulls one byte per subblock,
// inverts the g0 stream bit-serially, writes info bytes out and tallies g1/g2 mismatches.
module conv_decoder_bs
  import conv_code_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  conv_decoder_bs_if.slave bus
);

  dec_state_e            state_q, state_d;
  logic                  len_large_q, len_large_d;
  logic [SR_W-1:0]       s_q, s_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]     d0_sr_q, d0_sr_d;
  logic [BYTE_W-1:0]     d1_sr_q, d1_sr_d;
  logic [BYTE_W-1:0]     d2_sr_q, d2_sr_d;
  logic [BYTE_W-2:0]     out_sr_q, out_sr_d;
  logic [BYTE_W-1:0]     out_data_q, out_data_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  bit_c;
  logic [1:0]            mis_cnt_c;
  logic [CNT_W-1:0]      last_idx_c;
  logic [ERR_SUM_W-1:0]  err_sum_c;
  logic [ERR_W-1:0]      err_sat_c;

  conv_bit_inverter u_inv (
    .d0_i      (d0_sr_q[BYTE_W-1]),
    .d1_i      (d1_sr_q[BYTE_W-1]),
    .d2_i      (d2_sr_q[BYTE_W-1]),
    .s_i       (s_q),
    .bit_c     (bit_c),
    .mis_cnt_c (mis_cnt_c)
  );

  assign last_idx_c = len_large_q ? CNT_W'(LEN_LARGE_BYTES - 1) : CNT_W'(LEN_SMALL_BYTES - 1);
  assign err_sum_c  = {1'b0, err_q} + ERR_SUM_W'(mis_cnt_c);
  assign err_sat_c  = err_sum_c[ERR_W] ? '1 : err_sum_c[ERR_W-1:0];

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    len_large_d = len_large_q;
    s_d         = s_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    d0_sr_d     = d0_sr_q;
    d1_sr_d     = d1_sr_q;
    d2_sr_d     = d2_sr_q;
    out_sr_d    = out_sr_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_large_d = bus.code_block_length;
          s_d         = bus.init_state;
          err_d       = '0;
          byte_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!bus.empty) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        d0_sr_d   = bus.q0;
        d1_sr_d   = bus.q1;
        d2_sr_d   = bus.q2;
        bit_cnt_d = '0;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        s_d       = {s_q[SR_W-2:0], bit_c};
        out_sr_d  = {out_sr_q[BYTE_W-3:0], bit_c};
        d0_sr_d   = {d0_sr_q[BYTE_W-2:0], 1'b0};
        d1_sr_d   = {d1_sr_q[BYTE_W-2:0], 1'b0};
        d2_sr_d   = {d2_sr_q[BYTE_W-2:0], 1'b0};
        err_d     = err_sat_c;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        // out_data only moves once a whole byte is ready, so it is stable through WRITE.
        if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
          out_data_d = {out_sr_q, bit_c};
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus.out_full) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == last_idx_c) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_large_q <= 1'b0;
      s_q         <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      d0_sr_q     <= '0;
      d1_sr_q     <= '0;
      d2_sr_q     <= '0;
      out_sr_q    <= '0;
      out_data_q  <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_large_q <= len_large_d;
      s_q         <= s_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      d0_sr_q     <= d0_sr_d;
      d1_sr_q     <= d1_sr_d;
      d2_sr_q     <= d2_sr_d;
      out_sr_q    <= out_sr_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // FIFO strobes must act on the full/empty flags of the same cycle, hence decoded from state.
  assign bus.rdreq_subblock = (state_q == ST_FETCH) && !bus.empty;
  assign bus.out_wrreq      = (state_q == ST_WRITE) && !bus.out_full;
  assign bus.out_data       = out_data_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_count      = err_q;

endmodule
